// File: rtl/rv32i_types.sv
// Shared RV32I load/store encodings, access-unit FSM states and the
// accept-time legality check used by the memory access unit.
package rv32i_types;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mau_state_t;

  // 1 when the request must be refused: unknown funct3 or unaligned half/word.
  function automatic logic access_fault(input logic is_write, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (is_write) begin
      case (f3)
        SB:      bad = 1'b0;
        SH:      bad = off[0];
        SW:      bad = (off != 2'b00);
        default: bad = 1'b1;
      endcase
    end else begin
      case (f3)
        LB, LBU: bad = 1'b0;
        LH, LHU: bad = off[0];
        LW:      bad = (off != 2'b00);
        default: bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store lane enables/replicated data and
// load extraction with sign or zero extension.
module mem_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] load_ext
);

  logic [31:0] rsh_s;

  assign rsh_s = rdata >> {off, 3'b000};

  // Store side: replicate the datum across lanes so the enable alone selects it.
  always_comb begin
    be       = 4'b0000;
    wdata_sh = 32'h0000_0000;
    case (funct3)
      SB: begin
        be       = 4'b0001 << off;
        wdata_sh = {4{wdata[7:0]}};
      end
      SH: begin
        be       = 4'b0011 << off;
        wdata_sh = {2{wdata[15:0]}};
      end
      SW: begin
        be       = 4'b1111;
        wdata_sh = wdata;
      end
      default: begin
        be       = 4'b0000;
        wdata_sh = 32'h0000_0000;
      end
    endcase
  end

  // Load side: extend the shifted word according to the load width.
  always_comb begin
    load_ext = 32'h0000_0000;
    case (funct3)
      LB:      load_ext = {{24{rsh_s[7]}}, rsh_s[7:0]};
      LH:      load_ext = {{16{rsh_s[15]}}, rsh_s[15:0]};
      LW:      load_ext = rsh_s;
      LBU:     load_ext = {24'h00_0000, rsh_s[7:0]};
      LHU:     load_ext = {16'h0000, rsh_s[15:0]};
      default: load_ext = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store port stage: accepts one access per start, runs the word-addressed
// memory handshake with optional timeout, and reports done/fault to control.
module mem_access_unit
  import rv32i_types::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_read,
  input  logic        start_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
  localparam logic TO_EN = (TIMEOUT_CYCLES > 0);

  mau_state_t        state_r;
  logic [2:0]        funct3_r;
  logic [1:0]        off_r;
  logic              is_write_r;
  logic [CNT_W-1:0]  cnt_r;

  logic [2:0]  align_f3_s;
  logic [1:0]  align_off_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_sh_s;
  logic [31:0] load_ext_s;
  logic        start_s;
  logic        accept_fault_s;
  logic        timeout_s;

  assign start_s        = start_read | start_write;
  assign accept_fault_s = access_fault(start_write, funct3, addr_in[1:0]);
  assign timeout_s      = TO_EN && (cnt_r == TO_LAST);

  // One aligner serves both phases: live request while idle, latched fields afterwards.
  always_comb begin
    if (state_r == IDLE) begin
      align_f3_s  = funct3;
      align_off_s = addr_in[1:0];
    end else begin
      align_f3_s  = funct3_r;
      align_off_s = off_r;
    end
  end

  mem_align u_align (
    .funct3   (align_f3_s),
    .off      (align_off_s),
    .wdata    (wdata_in),
    .rdata    (mem_rdata),
    .be       (be_s),
    .wdata_sh (wdata_sh_s),
    .load_ext (load_ext_s)
  );

  // Access FSM with registered handshake, status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      funct3_r        <= 3'b000;
      off_r           <= 2'b00;
      is_write_r      <= 1'b0;
      cnt_r           <= '0;
      mem_address     <= 32'h0000_0000;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_byte_enable <= 4'b0000;
      mem_wdata       <= 32'h0000_0000;
      load_data       <= 32'h0000_0000;
      busy            <= 1'b0;
      done            <= 1'b0;
      fault           <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done  <= 1'b0;
          fault <= 1'b0;
          cnt_r <= '0;
          if (start_s) begin
            funct3_r        <= funct3;
            off_r           <= addr_in[1:0];
            is_write_r      <= start_write;
            mem_address     <= {addr_in[31:2], 2'b00};
            mem_byte_enable <= start_write ? be_s : 4'b1111;
            mem_wdata       <= start_write ? wdata_sh_s : 32'h0000_0000;
            busy            <= 1'b1;
            if (accept_fault_s) begin
              state_r <= DONE;
              done    <= 1'b1;
              fault   <= 1'b1;
            end else begin
              state_r   <= ACCESS;
              mem_read  <= ~start_write;
              mem_write <= start_write;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ACCESS: begin
          if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            done      <= 1'b1;
            fault     <= 1'b0;
            state_r   <= DONE;
            if (!is_write_r) begin
              load_data <= load_ext_s;
            end else begin
              load_data <= load_data;
            end
          end else if (timeout_s) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            done      <= 1'b1;
            fault     <= 1'b1;
            state_r   <= DONE;
            cnt_r     <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          done    <= 1'b0;
          fault   <= 1'b0;
          busy    <= 1'b0;
          cnt_r   <= '0;
          state_r <= IDLE;
        end
        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          done      <= 1'b0;
          fault     <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected completions are queued at
// request time and compared when the unit signals done.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_read, start_write;
  logic [2:0]  funct3;
  logic [31:0] addr_in, wdata_in;
  logic [31:0] mem_address;
  logic        mem_read, mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_resp;
  logic [31:0] load_data;
  logic        busy, done, fault;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start_read(start_read), .start_write(start_write),
    .funct3(funct3), .addr_in(addr_in), .wdata_in(wdata_in),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .load_data(load_data), .busy(busy), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic fault; logic [31:0] ld; } exp_t;
  typedef struct packed {
    logic [7:0]  strobes;
    logic [7:0]  wstrobes;
    logic [7:0]  both;
    logic [7:0]  done_cyc;
    logic        fault;
    logic [31:0] ld;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } obs_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_ld = 32'h0;

  task automatic pulse_start(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd);
    @(posedge clk); #1;
    start_write = wr; start_read = ~wr; funct3 = f3; addr_in = a; wdata_in = wd;
    @(posedge clk); #1;
    start_write = 1'b0; start_read = 1'b0;
  endtask

  // Memory model: answers on the (resp_after+1)-th strobe cycle; -1 never answers.
  task automatic run_mem(input int resp_after, input logic [31:0] rdata, output obs_t o);
    int s, w, b, dc;
    s = 0; w = 0; b = 0; dc = 0;
    o = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) begin
        dc = c; o.fault = fault; o.ld = load_data; mem_resp = 1'b0;
        break;
      end
      if (mem_read || mem_write) begin
        if (s == 0) begin o.addr = mem_address; o.be = mem_byte_enable; o.wd = mem_wdata; end
        if (mem_write) w++;
        if (mem_read && mem_write) b++;
        if (s == resp_after) begin mem_resp = 1'b1; mem_rdata = rdata; end
        else begin mem_resp = 1'b0; mem_rdata = 32'hDEAD_BEEF; end
        s++;
      end else begin
        mem_resp = 1'b0;
      end
    end
    mem_resp = 1'b0;
    o.strobes = 8'(s); o.wstrobes = 8'(w); o.both = 8'(b); o.done_cyc = 8'(dc);
  endtask

  task automatic test_reset();
    rst = 1'b1; start_read = 1'b0; start_write = 1'b0; funct3 = 3'b000;
    addr_in = 32'h0; wdata_in = 32'h0; mem_rdata = 32'h0; mem_resp = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if ({mem_read, mem_write, busy, done, fault} !== 5'b00000) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=00000", {mem_read, mem_write, busy, done, fault});
    end
    total++; if (load_data !== 32'h0 || mem_address !== 32'h0) begin
      bad++; $display("FAIL reset_data got ld=%h addr=%h exp=0", load_data, mem_address);
    end
    total++; if (mem_byte_enable !== 4'b0000 || mem_wdata !== 32'h0) begin
      bad++; $display("FAIL reset_lanes got be=%b wd=%h exp=0", mem_byte_enable, mem_wdata);
    end
  endtask

  task automatic test_lb();
    obs_t o; exp_t e;
    model_ld = 32'hFFFF_FF80;
    sb_q.push_back('{fault: 1'b0, ld: model_ld});
    pulse_start(1'b0, 3'b000, 32'h0000_1003, 32'h0);
    run_mem(0, 32'h80FF_0000, o);
    e = sb_q.pop_front();
    total++; if (o.ld !== e.ld || o.fault !== e.fault) begin
      bad++; $display("FAIL lb_result got ld=%h f=%b exp ld=%h f=%b", o.ld, o.fault, e.ld, e.fault);
    end
    total++; if (o.addr !== 32'h0000_1000 || o.be !== 4'b1111) begin
      bad++; $display("FAIL lb_addr got addr=%h be=%b exp 00001000 1111", o.addr, o.be);
    end
    total++; if (o.done_cyc !== 8'd2 || o.strobes !== 8'd1) begin
      bad++; $display("FAIL lb_latency got done=%0d strobes=%0d exp 2 1", o.done_cyc, o.strobes);
    end
  endtask

  task automatic test_lhu_wait();
    obs_t o; exp_t e;
    model_ld = 32'h0000_BEEF;
    sb_q.push_back('{fault: 1'b0, ld: model_ld});
    pulse_start(1'b0, 3'b101, 32'h0000_2002, 32'h0);
    run_mem(3, 32'hBEEF_1234, o);
    e = sb_q.pop_front();
    total++; if (o.ld !== e.ld || o.fault !== e.fault) begin
      bad++; $display("FAIL lhu_result got ld=%h f=%b exp ld=%h f=%b", o.ld, o.fault, e.ld, e.fault);
    end
    total++; if (o.strobes !== 8'd4 || o.done_cyc !== 8'd5 || o.wstrobes !== 8'd0) begin
      bad++; $display("FAIL lhu_strobe got rd=%0d wr=%0d done=%0d exp 4 0 5", o.strobes, o.wstrobes, o.done_cyc);
    end
  endtask

  task automatic test_sb();
    obs_t o; exp_t e;
    sb_q.push_back('{fault: 1'b0, ld: model_ld});
    pulse_start(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5);
    run_mem(2, 32'h0, o);
    e = sb_q.pop_front();
    total++; if (o.be !== 4'b0010 || o.wd !== 32'hA5A5_A5A5 || o.addr !== 32'h0000_3000) begin
      bad++; $display("FAIL sb_lanes got be=%b wd=%h addr=%h exp 0010 a5a5a5a5 00003000", o.be, o.wd, o.addr);
    end
    total++; if (o.wstrobes !== 8'd3 || o.strobes !== 8'd3 || o.both !== 8'd0) begin
      bad++; $display("FAIL sb_strobe got wr=%0d all=%0d both=%0d exp 3 3 0", o.wstrobes, o.strobes, o.both);
    end
    total++; if (o.ld !== e.ld || o.fault !== e.fault) begin
      bad++; $display("FAIL sb_result got ld=%h f=%b exp ld=%h f=%b", o.ld, o.fault, e.ld, e.fault);
    end
  endtask

  task automatic test_faults();
    obs_t o; exp_t e;
    logic        wr[3] = '{1'b0, 1'b0, 1'b1};
    logic [2:0]  f3[3] = '{3'b010, 3'b011, 3'b001};
    logic [31:0] ad[3] = '{32'h0000_4002, 32'h0000_4000, 32'h0000_5001};
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{fault: 1'b1, ld: model_ld});
      pulse_start(wr[i], f3[i], ad[i], 32'h1234_5678);
      run_mem(0, 32'h5555_5555, o);
      e = sb_q.pop_front();
      total++; if (o.fault !== e.fault || o.ld !== e.ld) begin
        bad++; $display("FAIL fault_%0d got f=%b ld=%h exp f=%b ld=%h", i, o.fault, o.ld, e.fault, e.ld);
      end
      total++; if (o.done_cyc !== 8'd1 || o.strobes !== 8'd0) begin
        bad++; $display("FAIL fault_%0d_timing got done=%0d strobes=%0d exp 1 0", i, o.done_cyc, o.strobes);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e;
    sb_q.push_back('{fault: 1'b1, ld: model_ld});
    pulse_start(1'b0, 3'b010, 32'h0000_6000, 32'h0);
    run_mem(-1, 32'h0, o);
    e = sb_q.pop_front();
    total++; if (o.fault !== e.fault || o.ld !== e.ld) begin
      bad++; $display("FAIL timeout_result got f=%b ld=%h exp f=%b ld=%h", o.fault, o.ld, e.fault, e.ld);
    end
    total++; if (o.strobes !== 8'(TO) || o.done_cyc !== 8'(TO + 1)) begin
      bad++; $display("FAIL timeout_len got strobes=%0d done=%0d exp %0d %0d", o.strobes, o.done_cyc, TO, TO + 1);
    end
    model_ld = 32'h1234_5678;
    sb_q.push_back('{fault: 1'b0, ld: model_ld});
    pulse_start(1'b0, 3'b010, 32'h0000_6004, 32'h0);
    run_mem(0, 32'h1234_5678, o);
    e = sb_q.pop_front();
    total++; if (o.fault !== e.fault || o.ld !== e.ld || o.done_cyc !== 8'd2) begin
      bad++; $display("FAIL after_timeout got f=%b ld=%h done=%0d exp f=%b ld=%h done=2", o.fault, o.ld, o.done_cyc, e.fault, e.ld);
    end
  endtask

  task automatic test_extract();
    obs_t o; exp_t e;
    logic        wr[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3[7] = '{3'b001, 3'b100, 3'b000, 3'b001, 3'b010, 3'b010, 3'b000};
    logic [31:0] ad[7] = '{32'h7002, 32'h7001, 32'h7000, 32'h7002, 32'h7004, 32'h7008, 32'h7003};
    logic [31:0] wd[7] = '{32'h0, 32'h0, 32'h0, 32'h1234_BEEF, 32'hCAFE_F00D, 32'h0, 32'h0000_0011};
    logic [31:0] rd[7] = '{32'h8001_0000, 32'h0000_8000, 32'h0000_007F, 32'h0, 32'h0, 32'h8765_4321, 32'h0};
    logic [31:0] xl[7] = '{32'hFFFF_8001, 32'h0000_0080, 32'h0000_007F, 32'h0000_007F,
                           32'h0000_007F, 32'h8765_4321, 32'h8765_4321};
    logic [3:0]  xb[7] = '{4'b1111, 4'b1111, 4'b1111, 4'b1100, 4'b1111, 4'b1111, 4'b1000};
    logic [31:0] xw[7] = '{32'h0, 32'h0, 32'h0, 32'hBEEF_BEEF, 32'hCAFE_F00D, 32'h0, 32'h1111_1111};
    for (int i = 0; i < 7; i++) begin
      model_ld = xl[i];
      sb_q.push_back('{fault: 1'b0, ld: model_ld});
      pulse_start(wr[i], f3[i], ad[i], wd[i]);
      run_mem(1, rd[i], o);
      e = sb_q.pop_front();
      total++; if (o.ld !== e.ld || o.fault !== e.fault) begin
        bad++; $display("FAIL extract_%0d got ld=%h f=%b exp ld=%h f=%b", i, o.ld, o.fault, e.ld, e.fault);
      end
      total++; if (o.be !== xb[i] || (wr[i] && o.wd !== xw[i])) begin
        bad++; $display("FAIL lanes_%0d got be=%b wd=%h exp be=%b wd=%h", i, o.be, o.wd, xb[i], xw[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o; exp_t e;
    for (int i = 0; i < 2; i++) begin
      model_ld = 32'h0A0B_0C00 + 32'(i);
      sb_q.push_back('{fault: 1'b0, ld: model_ld});
      pulse_start(1'b0, 3'b010, 32'h0000_A000 + 32'(4 * i), 32'h0);
      run_mem(0, model_ld, o);
      e = sb_q.pop_front();
      total++; if (o.ld !== e.ld || o.done_cyc !== 8'd2) begin
        bad++; $display("FAIL b2b_%0d got ld=%h done=%0d exp ld=%h done=2", i, o.ld, o.done_cyc, e.ld);
      end
    end
  endtask

  task automatic test_busy_hold();
    exp_t e;
    int rises, dones, s;
    logic prev;
    logic [31:0] ld;
    rises = 0; dones = 0; s = 0; prev = 1'b0; ld = 32'h0;
    model_ld = 32'h0BAD_F00D;
    sb_q.push_back('{fault: 1'b0, ld: model_ld});
    @(posedge clk); #1;
    start_read = 1'b1; funct3 = 3'b010; addr_in = 32'h0000_9000;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_read && !prev) rises++;
      prev = mem_read;
      if (done) begin dones++; ld = load_data; start_read = 1'b0; end
      if (mem_read) begin
        mem_resp = (s == 2); mem_rdata = (s == 2) ? 32'h0BAD_F00D : 32'hDEAD_BEEF; s++;
      end else begin
        mem_resp = 1'b0;
      end
    end
    start_read = 1'b0; mem_resp = 1'b0;
    e = sb_q.pop_front();
    total++; if (rises !== 1 || dones !== 1) begin
      bad++; $display("FAIL busy_hold got accesses=%0d dones=%0d exp 1 1", rises, dones);
    end
    total++; if (ld !== e.ld) begin
      bad++; $display("FAIL busy_hold_data got ld=%h exp ld=%h", ld, e.ld);
    end
  endtask

  task automatic test_rst_mid();
    logic seen;
    seen = 1'b0;
    pulse_start(1'b0, 3'b010, 32'h0000_8000, 32'h0);
    @(negedge clk); @(negedge clk);
    total++; if (mem_read !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL rst_mid_pre got rd=%b busy=%b exp 1 1", mem_read, busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_resp = 1'b1; mem_rdata = 32'h1234_5678;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || mem_read || mem_write) seen = 1'b1;
    end
    mem_resp = 1'b0;
    model_ld = 32'h0;
    total++; if (seen !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_mid_quiet got activity=%b busy=%b exp 0 0", seen, busy);
    end
    total++; if (load_data !== model_ld) begin
      bad++; $display("FAIL rst_mid_ld got ld=%h exp ld=%h", load_data, model_ld);
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_lhu_wait();
    test_sb();
    test_faults();
    test_timeout();
    test_extract();
    test_back_to_back();
    test_busy_hold();
    test_rst_mid();
    total++; if (sb_q.size() !== 0) begin
      bad++; $display("FAIL scoreboard_left got=%0d exp=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
